// File: rtl/pipeline_halt_monitor.sv
// pipeline_halt_monitor: detects the jal x0,0 end-of-program self-loop and counts cycles/retirements up to it
module pipeline_halt_monitor #(
    parameter int          CNT_W        = 32,
    parameter logic [31:0] HALT_INSN    = 32'h0000006F,
    parameter int          HALT_CONFIRM = 2,
    parameter int          TIMEOUT      = 10000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [31:0]      fetch_instruction,
    input  logic [31:0]      decode_instruction,
    input  logic             retire_valid,
    output logic             busy,
    output logic             halted,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] halt_cycles,
    output logic [CNT_W-1:0] retired_count
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RUN     = 3'd1;
    localparam logic [2:0] S_CONFIRM = 3'd2;
    localparam logic [2:0] S_HALTED  = 3'd3;
    localparam logic [2:0] S_TIMEOUT = 3'd4;
    localparam int CW = HALT_CONFIRM > 1 ? $clog2(HALT_CONFIRM) : 1;
    localparam logic [CNT_W-1:0] ONE = 1;
    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(HALT_CONFIRM - 1);

    logic [2:0]       state;
    logic [CW-1:0]    confirm;
    logic             hc;
    logic             tmo;
    logic [CNT_W-1:0] cyc_inc;
    logic [CNT_W-1:0] ret_inc;

    assign hc      = (fetch_instruction == HALT_INSN) && (decode_instruction == 32'h0);
    assign tmo     = cycle_count == TO_VAL;
    assign cyc_inc = &cycle_count ? cycle_count : cycle_count + ONE;
    assign ret_inc = &retired_count ? retired_count : retired_count + ONE;

    assign busy    = (state == S_RUN) || (state == S_CONFIRM);
    assign halted  = state == S_HALTED;
    assign timeout = state == S_TIMEOUT;

    // state machine and counters; halt confirmation beats timeout, both still count on that edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst || clear) begin
            state         <= S_IDLE;
            confirm       <= '0;
            cycle_count   <= '0;
            halt_cycles   <= '0;
            retired_count <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (fetch_instruction != 32'h0) begin
                        state         <= S_RUN;
                        cycle_count   <= ONE;
                        retired_count <= retire_valid ? ONE : '0;
                    end
                end
                S_RUN, S_CONFIRM: begin
                    cycle_count <= cyc_inc;
                    if (retire_valid)
                        retired_count <= ret_inc;
                    if (state == S_RUN) begin
                        if (hc)
                            halt_cycles <= cycle_count;
                        if (hc && HALT_CONFIRM == 1)
                            state <= S_HALTED;
                        else if (tmo)
                            state <= S_TIMEOUT;
                        else if (hc) begin
                            state   <= S_CONFIRM;
                            confirm <= CW'(1);
                        end
                    end else begin
                        if (hc && confirm == LAST)
                            state <= S_HALTED;
                        else if (tmo)
                            state <= S_TIMEOUT;
                        else if (!hc)
                            state <= S_RUN;
                        else
                            confirm <= confirm + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_pipeline_halt_monitor.sv
// tb_pipeline_halt_monitor: directed and randomized checks against a streak-based reference model
module tb_pipeline_halt_monitor;
    localparam int HC = 2;
    localparam int TO = 50;
    localparam logic [31:0] HALT = 32'h0000006F;

    logic        clk = 0;
    logic        rst = 1;
    logic        clear = 0;
    logic [31:0] fetch_instruction = 0;
    logic [31:0] decode_instruction = 0;
    logic        retire_valid = 0;
    logic        busy, halted, timeout;
    logic [31:0] cycle_count, halt_cycles, retired_count;

    int n_chk = 0;
    int n_fail = 0;

    bit          m_run, m_halt, m_tout;
    int unsigned m_cyc, m_hcap, m_ret, m_streak;

    pipeline_halt_monitor #(.CNT_W(32), .HALT_INSN(HALT), .HALT_CONFIRM(HC), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .fetch_instruction(fetch_instruction), .decode_instruction(decode_instruction),
        .retire_valid(retire_valid), .busy(busy), .halted(halted), .timeout(timeout),
        .cycle_count(cycle_count), .halt_cycles(halt_cycles), .retired_count(retired_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void m_reset();
        m_run = 0; m_halt = 0; m_tout = 0;
        m_cyc = 0; m_hcap = 0; m_ret = 0; m_streak = 0;
    endfunction

    // reference: a run halts once the halt pattern has been seen HC edges in a row,
    // halt_cycles is the count at the start of the latest streak
    function automatic void m_edge(input logic [31:0] f, input logic [31:0] d, input bit r, input bit c);
        bit hit, fin;
        hit = (f == HALT) && (d == 0);
        fin = 0;
        if (c) m_reset();
        else if (m_halt || m_tout) ;
        else if (!m_run) begin
            if (f != 0) begin m_run = 1; m_cyc = 1; m_ret = r; end
        end else begin
            if (hit) begin
                if (m_streak == 0) m_hcap = m_cyc;
                m_streak++;
                fin = m_streak >= HC;
            end else m_streak = 0;
            if (fin) begin m_halt = 1; m_run = 0; end
            else if (m_cyc == TO) begin m_tout = 1; m_run = 0; end
            m_cyc++;
            m_ret += r;
        end
    endfunction

    task automatic check_all(input string p);
        chk({p, ".busy"}, 32'(busy), 32'(m_run));
        chk({p, ".halted"}, 32'(halted), 32'(m_halt));
        chk({p, ".timeout"}, 32'(timeout), 32'(m_tout));
        chk({p, ".cycle_count"}, cycle_count, m_cyc);
        chk({p, ".halt_cycles"}, halt_cycles, m_hcap);
        chk({p, ".retired_count"}, retired_count, m_ret);
    endtask

    task automatic step(input logic [31:0] f, input logic [31:0] d, input bit r, input bit c);
        fetch_instruction = f; decode_instruction = d; retire_valid = r; clear = c;
        @(posedge clk);
        m_edge(f, d, r, c);
        #1;
        check_all("step");
    endtask

    task automatic run_to(input int unsigned n);
        while (m_cyc < n && m_run) step(32'h13, 32'h13, 0, 0);
    endtask

    initial begin
        m_reset();
        #1;
        check_all("reset_async");
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 0;
        check_all("reset");

        // normal halt: 5 retirements, halt pattern from count 20
        step(32'h13, 32'h13, 0, 0);
        chk("start_cycle", cycle_count, 1);
        while (m_cyc < 20) step(32'h13, 32'h13, m_cyc <= 5, 0);
        step(HALT, 0, 0, 0);
        chk("confirm_not_halted", 32'(halted), 0);
        step(HALT, 0, 0, 0);
        chk("halted", 32'(halted), 1);
        chk("halt_cycles_20", halt_cycles, 20);
        chk("retired_5", retired_count, 5);
        chk("halted_cycle", cycle_count, 22);
        repeat (3) step($urandom, $urandom, 1, 0);
        chk("frozen_cycle", cycle_count, 22);
        chk("frozen_retire", retired_count, 5);

        // clear in HALTED
        step(0, 0, 0, 1);
        chk("clear_halt_cycle", cycle_count, 0);
        chk("clear_halt_busy", 32'(busy | halted | timeout), 0);

        // glitch rejection
        step(32'h13, 32'h13, 0, 0);
        run_to(10);
        step(HALT, 0, 0, 0);
        step(32'h13, 32'h13, 0, 0);
        chk("glitch_back_to_run", 32'(busy), 1);
        chk("glitch_hcap", halt_cycles, 10);
        run_to(30);
        step(HALT, 0, 0, 0);
        step(HALT, 0, 0, 0);
        chk("glitch_halted", 32'(halted), 1);
        chk("glitch_final_hcap", halt_cycles, 30);
        step(0, 0, 0, 1);

        // timeout
        step(32'h13, 32'h13, 0, 0);
        run_to(TO);
        chk("pre_timeout", 32'(timeout), 0);
        step(32'h13, 32'h13, 0, 0);
        chk("timeout", 32'(timeout), 1);
        chk("timeout_cycle", cycle_count, TO + 1);
        repeat (2) step(32'h13, 32'h13, 1, 0);
        chk("timeout_frozen", cycle_count, TO + 1);
        step(0, 0, 0, 1);

        // halt confirmation on the timeout edge wins
        step(32'h13, 32'h13, 0, 0);
        run_to(TO - 1);
        step(HALT, 0, 0, 0);
        step(HALT, 0, 0, 0);
        chk("tie_halted", 32'(halted), 1);
        chk("tie_timeout", 32'(timeout), 0);
        step(0, 0, 0, 1);

        // clear mid-CONFIRM then restart
        step(32'h13, 32'h13, 1, 0);
        run_to(7);
        step(HALT, 0, 0, 0);
        step(HALT, 0, 0, 1);
        chk("clear_confirm_idle", 32'(busy), 0);
        step(32'h13, 32'h13, 0, 0);
        chk("restart_cycle", cycle_count, 1);

        // asynchronous reset between edges
        run_to(12);
        #3 rst = 1;
        #1;
        chk("async_busy", 32'(busy), 0);
        chk("async_cycle", cycle_count, 0);
        chk("async_halted", 32'(halted), 0);
        m_reset();
        @(posedge clk);
        @(negedge clk) rst = 0;
        check_all("after_async");

        // randomized runs
        for (int run = 0; run < 30; run++) begin
            int p;
            case (run % 4)
                0: p = 0;
                1: p = 20;
                2: p = 60;
                default: p = 95;
            endcase
            step(32'h13, 32'h13, $urandom_range(0, 1), 0);
            for (int i = 0; i < 70; i++) begin
                bit h;
                h = $urandom_range(0, 99) < p;
                step(h ? HALT : $urandom, h ? 32'h0 : $urandom, $urandom_range(0, 1), $urandom_range(0, 99) == 0);
            end
            step(0, 0, 0, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
